// File: rtl/spi_mosi_serializer.sv
// SPI mode-0 master transmit engine: one-entry holding buffer feeding an MSB-first
// shifter with generated spi_clk and frame select. Back-to-back words run as a burst.
module spi_mosi_serializer #(
  parameter int W_DATA  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] load_data_i,
  input  logic              load_valid_i,
  input  logic              clr_overrun_i,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              tx_done_o,
  output logic              overrun_o,
  output logic              spi_clk_o,
  output logic              spi_mosi_o,
  output logic              spi_cs_n_o
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W = $clog2(W_DATA);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(W_DATA - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_SHIFT_H = 3'd2;
  localparam logic [2:0] ST_SHIFT_L = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [W_DATA-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [W_DATA-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              overrun_q, overrun_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              hc_end_s;
  logic              start_frame_s;

  // Next-state logic: holding buffer, overrun flag and the frame FSM.
  always_comb begin
    state_d       = state_q;
    hc_d          = hc_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    overrun_d     = overrun_q;
    sclk_d        = sclk_q;
    mosi_d        = mosi_q;
    cs_n_d        = cs_n_q;
    tx_done_d     = 1'b0;
    start_frame_s = 1'b0;
    hc_end_s      = (hc_q == HC_MAX);

    // Acceptance looks only at the registered ready flag, never at a same-cycle drain.
    if (load_valid_i && tx_ready_q) begin
      buf_d      = load_data_i;
      buf_full_d = 1'b1;
    end else begin
      buf_d      = buf_q;
    end

    if (load_valid_i && !tx_ready_q) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        hc_d   = {HC_W{1'b0}};
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        if (buf_full_q) begin
          start_frame_s = 1'b1;
        end else begin
          start_frame_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (hc_end_s) begin
          hc_d    = {HC_W{1'b0}};
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_H;
        end else begin
          hc_d    = hc_q + HC_W'(1);
        end
      end
      ST_SHIFT_H: begin
        if (hc_end_s) begin
          hc_d   = {HC_W{1'b0}};
          sclk_d = 1'b0;
          if (bit_cnt_q == BC_LAST) begin
            tx_done_d = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            shreg_d   = {shreg_q[W_DATA-2:0], 1'b0};
            mosi_d    = shreg_q[W_DATA-2];
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            state_d   = ST_SHIFT_L;
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_SHIFT_L: begin
        if (hc_end_s) begin
          hc_d    = {HC_W{1'b0}};
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_H;
        end else begin
          hc_d    = hc_q + HC_W'(1);
        end
      end
      ST_HOLD: begin
        if (hc_end_s) begin
          hc_d = {HC_W{1'b0}};
          if (buf_full_q) begin
            start_frame_s = 1'b1;
          end else begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      default: begin
        hc_d    = {HC_W{1'b0}};
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Shared by IDLE and a burst continuation out of HOLD.
    if (start_frame_s) begin
      shreg_d    = buf_q;
      buf_full_d = 1'b0;
      bit_cnt_d  = {BC_W{1'b0}};
      cs_n_d     = 1'b0;
      mosi_d     = buf_q[W_DATA-1];
      hc_d       = {HC_W{1'b0}};
      state_d    = ST_SETUP;
    end else begin
      shreg_d    = shreg_d;
    end

    tx_ready_d = ~buf_full_d;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hc_q       <= {HC_W{1'b0}};
      buf_q      <= {W_DATA{1'b0}};
      buf_full_q <= 1'b0;
      shreg_q    <= {W_DATA{1'b0}};
      bit_cnt_q  <= {BC_W{1'b0}};
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      overrun_q  <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hc_q       <= hc_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      overrun_q  <= overrun_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign busy_o     = busy_q;
  assign tx_done_o  = tx_done_q;
  assign overrun_o  = overrun_q;
  assign spi_clk_o  = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_mosi_serializer.sv
// Directed bench: instance 0 runs CLK_DIV=2, instance 1 runs CLK_DIV=1 (both W_DATA=8).
module tb_spi_mosi_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_data [2];
  logic       load_valid [2];
  logic       clr_overrun [2];
  logic       tx_ready [2];
  logic       busy [2];
  logic       tx_done [2];
  logic       overrun [2];
  logic       spi_clk [2];
  logic       spi_mosi [2];
  logic       spi_cs_n [2];

  int n_checks = 0;
  int n_pass   = 0;

  int          rise_cnt [2];
  int          done_cnt [2];
  int          cs_low_cnt [2];
  int          cs_rise_cnt [2];
  int          ready_low_cnt [2];
  int          clk_high_cnt [2];
  logic [31:0] bits [2];
  logic        clk_prev [2];
  logic        cs_prev [2];

  always #5 clk = ~clk;

  spi_mosi_serializer #(.W_DATA(8), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .load_data_i(load_data[0]), .load_valid_i(load_valid[0]),
    .clr_overrun_i(clr_overrun[0]), .tx_ready_o(tx_ready[0]), .busy_o(busy[0]),
    .tx_done_o(tx_done[0]), .overrun_o(overrun[0]), .spi_clk_o(spi_clk[0]),
    .spi_mosi_o(spi_mosi[0]), .spi_cs_n_o(spi_cs_n[0])
  );

  spi_mosi_serializer #(.W_DATA(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_data_i(load_data[1]), .load_valid_i(load_valid[1]),
    .clr_overrun_i(clr_overrun[1]), .tx_ready_o(tx_ready[1]), .busy_o(busy[1]),
    .tx_done_o(tx_done[1]), .overrun_o(overrun[1]), .spi_clk_o(spi_clk[1]),
    .spi_mosi_o(spi_mosi[1]), .spi_cs_n_o(spi_cs_n[1])
  );

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; done_cnt[i] = 0; cs_low_cnt[i] = 0; cs_rise_cnt[i] = 0;
      ready_low_cnt[i] = 0; clk_high_cnt[i] = 0; bits[i] = 32'd0;
      clk_prev[i] = spi_clk[i]; cs_prev[i] = spi_cs_n[i];
    end
  endtask

  // Advance to the next falling clk edge and record what the SPI pins did.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (spi_clk[i] && !clk_prev[i]) begin
        rise_cnt[i]++;
        bits[i] = {bits[i][30:0], spi_mosi[i]};
      end
      if (tx_done[i]) done_cnt[i]++;
      if (!spi_cs_n[i]) cs_low_cnt[i]++;
      if (spi_cs_n[i] && !cs_prev[i]) cs_rise_cnt[i]++;
      if (!tx_ready[i]) ready_low_cnt[i]++;
      if (spi_clk[i]) clk_high_cnt[i]++;
      clk_prev[i] = spi_clk[i];
      cs_prev[i]  = spi_cs_n[i];
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int i, input logic [7:0] d);
    load_data[i] = d; load_valid[i] = 1'b1;
    step();
    load_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data[i] = 8'h00; load_valid[i] = 1'b0; clr_overrun[i] = 1'b0;
    end
    steps(3);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (tx_ready[i] !== 1'b1) $display("FAIL reset_tx_ready[%0d]: got %b expected 1", i, tx_ready[i]); else n_pass++;
      n_checks++; if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); else n_pass++;
      n_checks++; if (spi_cs_n[i] !== 1'b1) $display("FAIL reset_cs_n[%0d]: got %b expected 1", i, spi_cs_n[i]); else n_pass++;
      n_checks++; if ({spi_clk[i], spi_mosi[i], tx_done[i], overrun[i]} !== 4'b0000)
        $display("FAIL reset_outs[%0d]: got %b expected 0000", i, {spi_clk[i], spi_mosi[i], tx_done[i], overrun[i]}); else n_pass++;
    end
    rst = 1'b0;
    steps(2);
  endtask

  task automatic test_single_frame();
    clear_mon();
    load(0, 8'hA5);
    steps(45);
    n_checks++; if (cs_low_cnt[0] !== 34) $display("FAIL t1_cs_low: got %0d expected 34", cs_low_cnt[0]); else n_pass++;
    n_checks++; if (rise_cnt[0] !== 8) $display("FAIL t1_rises: got %0d expected 8", rise_cnt[0]); else n_pass++;
    n_checks++; if (bits[0][7:0] !== 8'hA5) $display("FAIL t1_bits: got %h expected a5", bits[0][7:0]); else n_pass++;
    n_checks++; if (done_cnt[0] !== 1) $display("FAIL t1_done: got %0d expected 1", done_cnt[0]); else n_pass++;
    n_checks++; if (ready_low_cnt[0] !== 1) $display("FAIL t1_ready_low: got %0d expected 1", ready_low_cnt[0]); else n_pass++;
    n_checks++; if (clk_high_cnt[0] !== 16) $display("FAIL t1_clk_high: got %0d expected 16", clk_high_cnt[0]); else n_pass++;
    n_checks++; if (busy[0] !== 1'b0) $display("FAIL t1_busy_after: got %b expected 0", busy[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    load(0, 8'h3C);
    steps(8);
    load(0, 8'hC3);
    steps(80);
    n_checks++; if (rise_cnt[0] !== 16) $display("FAIL t2_rises: got %0d expected 16", rise_cnt[0]); else n_pass++;
    n_checks++; if (bits[0][15:0] !== 16'h3CC3) $display("FAIL t2_bits: got %h expected 3cc3", bits[0][15:0]); else n_pass++;
    n_checks++; if (cs_rise_cnt[0] !== 1) $display("FAIL t2_cs_rises: got %0d expected 1", cs_rise_cnt[0]); else n_pass++;
    n_checks++; if (cs_low_cnt[0] !== 68) $display("FAIL t2_cs_low: got %0d expected 68", cs_low_cnt[0]); else n_pass++;
    n_checks++; if (done_cnt[0] !== 2) $display("FAIL t2_done: got %0d expected 2", done_cnt[0]); else n_pass++;
  endtask

  task automatic test_overrun();
    clear_mon();
    load(0, 8'h11);
    step();
    load(0, 8'h22);
    load(0, 8'h33);
    n_checks++; if (overrun[0] !== 1'b1) $display("FAIL t3_overrun_set: got %b expected 1", overrun[0]); else n_pass++;
    steps(90);
    n_checks++; if (rise_cnt[0] !== 16) $display("FAIL t3_rises: got %0d expected 16", rise_cnt[0]); else n_pass++;
    n_checks++; if (bits[0][15:0] !== 16'h1122) $display("FAIL t3_bits: got %h expected 1122", bits[0][15:0]); else n_pass++;
    n_checks++; if (overrun[0] !== 1'b1) $display("FAIL t3_overrun_sticky: got %b expected 1", overrun[0]); else n_pass++;
    clr_overrun[0] = 1'b1;
    step();
    clr_overrun[0] = 1'b0;
    n_checks++; if (overrun[0] !== 1'b0) $display("FAIL t3_overrun_clr: got %b expected 0", overrun[0]); else n_pass++;
  endtask

  task automatic test_overrun_priority();
    clear_mon();
    load(0, 8'h44);
    load_data[0] = 8'h55; load_valid[0] = 1'b1; clr_overrun[0] = 1'b1;
    step();
    load_valid[0] = 1'b0; clr_overrun[0] = 1'b0;
    n_checks++; if (overrun[0] !== 1'b1) $display("FAIL t6_set_wins: got %b expected 1", overrun[0]); else n_pass++;
    steps(45);
    n_checks++; if (bits[0][7:0] !== 8'h44 || rise_cnt[0] !== 8)
      $display("FAIL t6_frame: got %h/%0d expected 44/8", bits[0][7:0], rise_cnt[0]); else n_pass++;
    clr_overrun[0] = 1'b1;
    step();
    clr_overrun[0] = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    load(0, 8'h5A);
    for (int c = 0; c < 40 && rise_cnt[0] < 3; c++) step();
    n_checks++; if (rise_cnt[0] !== 3) $display("FAIL t4_reach_3rd_rise: got %0d expected 3", rise_cnt[0]); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({spi_cs_n[0], spi_clk[0], spi_mosi[0], tx_ready[0], busy[0]} !== 5'b10010)
      $display("FAIL t4_async_reset: got %b expected 10010", {spi_cs_n[0], spi_clk[0], spi_mosi[0], tx_ready[0], busy[0]}); else n_pass++;
    steps(2);
    rst = 1'b0;
    step();
    clear_mon();
    load(0, 8'hFF);
    steps(45);
    n_checks++; if (bits[0][7:0] !== 8'hFF || rise_cnt[0] !== 8)
      $display("FAIL t4_clean_frame: got %h/%0d expected ff/8", bits[0][7:0], rise_cnt[0]); else n_pass++;
    n_checks++; if (cs_low_cnt[0] !== 34) $display("FAIL t4_cs_low: got %0d expected 34", cs_low_cnt[0]); else n_pass++;
  endtask

  task automatic test_div1();
    clear_mon();
    load(1, 8'h80);
    steps(25);
    n_checks++; if (cs_low_cnt[1] !== 17) $display("FAIL t5_cs_low: got %0d expected 17", cs_low_cnt[1]); else n_pass++;
    n_checks++; if (rise_cnt[1] !== 8 || clk_high_cnt[1] !== 8)
      $display("FAIL t5_clk: got rises %0d high %0d expected 8/8", rise_cnt[1], clk_high_cnt[1]); else n_pass++;
    n_checks++; if (bits[1][7:0] !== 8'h80) $display("FAIL t5_bits: got %h expected 80", bits[1][7:0]); else n_pass++;
    clear_mon();
    load(1, 8'h00);
    step();
    load(1, 8'hFF);
    steps(45);
    n_checks++; if (bits[1][15:0] !== 16'h00FF || rise_cnt[1] !== 16)
      $display("FAIL t5_burst: got %h/%0d expected 00ff/16", bits[1][15:0], rise_cnt[1]); else n_pass++;
    n_checks++; if (cs_rise_cnt[1] !== 1 || done_cnt[1] !== 2)
      $display("FAIL t5_burst_frame: got cs_rises %0d done %0d expected 1/2", cs_rise_cnt[1], done_cnt[1]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_overrun_priority();
    test_reset_mid_frame();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
